mem_port_arbiter: RTL and testbench

//  Shares the single MEM-stage data port (data RAM + I/O space, selected by addr[7])

---
 rtl/mem_port_arbiter_if.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the MEM-stage port arbiter and its environment.
// Carries the CPU, debug and memory/IO bus signal groups.
interface mem_port_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;

  logic             dbg_req;
  logic             dbg_we;
  logic [31:0]      dbg_addr;
  logic [31:0]      dbg_wdata;
  logic             dbg_gnt;
  logic             dbg_rvalid;
  logic [31:0]      dbg_rdata;

  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;
  logic             bus_we;
  logic [31:0]      bus_rdata;

  logic [CNT_W-1:0] conflict_cnt;

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_rdata,
    output cpu_stall,
    input  dbg_req,
    input  dbg_we,
    input  dbg_addr,
    input  dbg_wdata,
    output dbg_gnt,
    output dbg_rvalid,
    output dbg_rdata,
    output bus_addr,
    output bus_wdata,
    output bus_we,
    input  bus_rdata,
    output conflict_cnt
  );

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_rdata,
    input  cpu_stall,
    output dbg_req,
    output dbg_we,
    output dbg_addr,
    output dbg_wdata,
    input  dbg_gnt,
    input  dbg_rvalid,
    input  dbg_rdata,
    input  bus_addr,
    input  bus_wdata,
    input  bus_we,
    output bus_rdata,
    input  conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the MEM-stage data port between the pipeline and a debug master.
// CPU has priority; a starvation counter forces a debug grant after STARVE_MAX losses.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic                i_mem_clk,
  input  logic                i_clrn,
  mem_port_arbiter_if.slave   io_arb
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    S_CPU,
    S_FORCE
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_starve;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;

  logic             w_both;
  logic             w_force;
  logic             w_dbg_own;
  logic             w_cpu_own;
  logic             w_stall;
  logic [SW-1:0]    w_starve_inc;

  assign w_both  = io_arb.cpu_req & io_arb.dbg_req;
  assign w_force = (r_state == S_FORCE);

  // All grants are gated by reset so no write can reach memory while clrn=0.
  assign w_dbg_own = i_clrn & io_arb.dbg_req
                   & (~io_arb.cpu_req | w_force);
  assign w_stall   = i_clrn & w_both & w_force;
  assign w_cpu_own = i_clrn & io_arb.cpu_req & ~w_dbg_own;

  assign w_starve_inc = r_starve + 1'b1;

  assign io_arb.bus_addr  = w_dbg_own ? io_arb.dbg_addr
                                      : io_arb.cpu_addr;
  assign io_arb.bus_wdata = w_dbg_own ? io_arb.dbg_wdata
                                      : io_arb.cpu_wdata;
  assign io_arb.bus_we    = w_dbg_own ? io_arb.dbg_we
                                      : (w_cpu_own & io_arb.cpu_we);

  assign io_arb.cpu_rdata    = io_arb.bus_rdata;
  assign io_arb.cpu_stall    = w_stall;
  assign io_arb.dbg_gnt      = w_dbg_own;
  assign io_arb.dbg_rvalid   = r_rvalid;
  assign io_arb.dbg_rdata    = r_rdata;
  assign io_arb.conflict_cnt = r_cnt;

  always_ff @(posedge i_mem_clk) begin
    if (!i_clrn) begin
      r_state  <= S_CPU;
      r_starve <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      r_rvalid <= w_dbg_own & ~io_arb.dbg_we;
      if (w_dbg_own && !io_arb.dbg_we) begin
        r_rdata <= io_arb.bus_rdata;
      end

      if (w_both && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Only consecutive conflicts build up starvation.
      if (!w_both || w_force) begin
        r_starve <= '0;
        r_state  <= S_CPU;
      end else begin
        r_starve <= w_starve_inc;
        if (w_starve_inc == SW'(STARVE_MAX)) begin
          r_state <= S_FORCE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small RAM/IO model.
// Directed per-cycle expectations are queued and checked by a monitor.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.CNT_W(16)) u_if ();

  mem_port_arbiter #(
    .STARVE_MAX(4),
    .CNT_W(16)
  ) dut (
    .i_mem_clk(clk),
    .i_clrn(rst_n),
    .io_arb(u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [32] = '{default: 32'h0};
  logic [31:0] io  [32] = '{default: 32'h0};

  assign u_if.bus_rdata = u_if.bus_addr[7] ? io[u_if.bus_addr[6:2]]
                                           : ram[u_if.bus_addr[6:2]];

  always @(posedge clk) begin
    if (u_if.bus_we) begin
      if (u_if.bus_addr[7]) io[u_if.bus_addr[6:2]] <= u_if.bus_wdata;
      else                  ram[u_if.bus_addr[6:2]] <= u_if.bus_wdata;
    end
  end

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        we;
    logic        rc;
    logic [31:0] rd;
    logic        cc_en;
    logic [15:0] cc;
    logic        bc;
    logic [31:0] ba;
    logic [31:0] bw;
    string       tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] rq[$];
  int          nvec = 0;
  int          nerr = 0;
  string       tag  = "init";

  function automatic exp_t E(input logic s, input logic g, input logic w);
    exp_t e;
    e.stall = s;
    e.gnt   = g;
    e.we    = w;
    e.rc    = 1'b0;
    e.rd    = '0;
    e.cc_en = 1'b0;
    e.cc    = '0;
    e.bc    = 1'b0;
    e.ba    = '0;
    e.bw    = '0;
    e.tag   = tag;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.tag, " cpu_stall"}, 32'(u_if.cpu_stall), 32'(e.stall));
      cmp({e.tag, " dbg_gnt"}, 32'(u_if.dbg_gnt), 32'(e.gnt));
      cmp({e.tag, " bus_we"}, 32'(u_if.bus_we), 32'(e.we));
      if (e.rc) cmp({e.tag, " cpu_rdata"}, u_if.cpu_rdata, e.rd);
      if (e.cc_en) cmp({e.tag, " conflict_cnt"},
                       32'(u_if.conflict_cnt), 32'(e.cc));
      if (e.bc) begin
        cmp({e.tag, " bus_addr"}, u_if.bus_addr, e.ba);
        cmp({e.tag, " bus_wdata"}, u_if.bus_wdata, e.bw);
      end
    end
    if (u_if.dbg_rvalid === 1'b1) begin
      if (rq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL dbg_rvalid: got unexpected pulse expected none");
      end else begin
        cmp("dbg_rdata", u_if.dbg_rdata, rq.pop_front());
      end
    end
  end

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    u_if.cpu_req   = r;
    u_if.cpu_we    = w;
    u_if.cpu_addr  = a;
    u_if.cpu_wdata = d;
  endtask

  task automatic dbg(input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    u_if.dbg_req   = r;
    u_if.dbg_we    = w;
    u_if.dbg_addr  = a;
    u_if.dbg_wdata = d;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    cpu(1, 1, 32'h10, 32'hDEAD);
    dbg(1, 1, 32'h14, 32'hBEEF);
    @(posedge clk);
    #1;

    // Reset: requests present but nothing may be granted or written.
    tag = "reset";
    step(E(0, 0, 0));
    e = E(0, 0, 0); e.cc_en = 1; e.cc = 0;
    step(e);
    rst_n = 1'b1;
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0);
    e = E(0, 0, 0); e.cc_en = 1; e.cc = 0;
    step(e);
    cmp("reset dbg_rdata", u_if.dbg_rdata, 32'h0);

    tag = "T1";
    cpu(1, 1, 32'h08, 32'h1234);
    step(E(0, 0, 1));
    cpu(1, 0, 32'h08, 32'h0);
    e = E(0, 0, 0); e.rc = 1; e.rd = 32'h1234;
    step(e);

    tag = "T2";
    cpu(0, 0, 0, 0);
    dbg(1, 0, 32'h08, 0);
    rq.push_back(32'h1234);
    step(E(0, 1, 0));
    dbg(0, 0, 0, 0);
    step(E(0, 0, 0));

    tag = "T3";
    cpu(1, 0, 32'h08, 0);
    dbg(1, 0, 32'h08, 0);
    for (int i = 1; i <= 4; i++) begin
      e = E(0, 0, 0); e.cc_en = 1; e.cc = 16'(i - 1);
      step(e);
    end
    rq.push_back(32'h1234);
    e = E(1, 1, 0); e.cc_en = 1; e.cc = 16'd4;
    step(e);
    step(E(0, 0, 0));
    dbg(0, 0, 0, 0);
    e = E(0, 0, 0); e.cc_en = 1; e.cc = 16'd6;
    step(e);

    tag = "T4";
    cpu(1, 1, 32'h0C, 32'hAAAA);
    dbg(1, 1, 32'h80, 32'h5);
    for (int i = 0; i < 4; i++) step(E(0, 0, 1));
    e = E(1, 1, 1); e.bc = 1; e.ba = 32'h80; e.bw = 32'h5;
    step(e);
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0);
    step(E(0, 0, 0));
    cpu(1, 0, 32'h80, 0);
    e = E(0, 0, 0); e.rc = 1; e.rd = 32'h5; e.cc_en = 1; e.cc = 16'd11;
    step(e);

    tag = "T5";
    cpu(1, 0, 32'h00, 0);
    dbg(1, 0, 32'h0C, 0);
    for (int i = 0; i < 3; i++) step(E(0, 0, 0));
    dbg(0, 0, 32'h0C, 0);
    step(E(0, 0, 0));
    dbg(1, 0, 32'h0C, 0);
    for (int i = 0; i < 4; i++) step(E(0, 0, 0));
    rq.push_back(32'hAAAA);
    step(E(1, 1, 0));
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0);
    e = E(0, 0, 0); e.cc_en = 1; e.cc = 16'd19;
    step(e);

    tag = "T6";
    cpu(1, 0, 32'h00, 0);
    dbg(1, 1, 32'h84, 32'h77);
    for (int i = 0; i < 4; i++) step(E(0, 0, 0));
    rst_n = 1'b0;
    step(E(0, 0, 0));
    rst_n = 1'b1;
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0);
    e = E(0, 0, 0); e.cc_en = 1; e.cc = 16'd0;
    step(e);
    cmp("T6 dbg_rdata", u_if.dbg_rdata, 32'h0);
    cpu(1, 0, 32'h84, 0);
    e = E(0, 0, 0); e.rc = 1; e.rd = 32'h0;
    step(e);
    cpu(1, 0, 32'h00, 0);
    dbg(1, 1, 32'h84, 32'h77);
    for (int i = 0; i < 4; i++) step(E(0, 0, 0));
    step(E(1, 1, 1));
    dbg(0, 0, 0, 0);
    cpu(1, 0, 32'h84, 0);
    e = E(0, 0, 0); e.rc = 1; e.rd = 32'h77; e.cc_en = 1; e.cc = 16'd5;
    step(e);

    tag = "end";
    cpu(0, 0, 0, 0);
    step(E(0, 0, 0));
    #10;
    nvec++;
    if (rq.size() != 0) begin
      nerr++;
      $display("FAIL dbg_rvalid pending: got %0d missing pulses expected 0",
               rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
